// File: rtl/exc_flush_ctrl_pkg.sv
// Shared types and constants for the exception flush sequencer.
package exc_flush_ctrl_pkg;

    typedef enum logic [1:0] {
        EXC_ST_IDLE   = 2'd0,
        EXC_ST_DRAIN  = 2'd1,
        EXC_ST_FLUSH  = 2'd2,
        EXC_ST_REFILL = 2'd3
    } exc_state_e;

    localparam logic [31:0] EXCEPT_TYPE_NONE = 32'h0000_0000;
    localparam logic [31:0] EXCEPT_TYPE_ERET = 32'h0000_000E;

    // Counter width able to hold max(a, b) - 1; never narrower than one bit.
    function automatic int unsigned exc_cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/exc_flush_ctrl_cycle_counter.sv
// Loadable down-counter that saturates at zero; shared by DRAIN and REFILL.
module exc_cycle_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/exc_flush_ctrl.sv
// Exception recovery sequencer: drain data bus, one-cycle flush with PC
// redirect and CP0 commit, then hold fetch until the instruction bus idles.
module exc_flush_ctrl
    import exc_flush_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_TIMEOUT = 16,
    parameter int unsigned REFILL_MIN    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] except_typeM,
    input  logic [31:0] newPcM,
    input  logic        dbus_busy,
    input  logic        ibus_busy,
    output logic        stall_all,
    output logic        flushF,
    output logic        flushD,
    output logic        flushE,
    output logic        flushM,
    output logic        flushW,
    output logic        pc_redirect_valid,
    output logic [31:0] pc_redirect,
    output logic        cp0_commit,
    output logic        eret_commit,
    output logic [4:0]  exc_code,
    output logic        drain_timeout,
    output logic        busy
);

    localparam int unsigned    CW          = exc_cnt_width(DRAIN_TIMEOUT, REFILL_MIN);
    localparam logic [CW-1:0]  DRAIN_LOAD  = CW'(DRAIN_TIMEOUT - 1);
    localparam logic [CW-1:0]  REFILL_LOAD = CW'(REFILL_MIN - 1);

    exc_state_e    r_state;
    exc_state_e    w_next;
    logic [31:0]   r_type_q;
    logic [31:0]   r_pc_q;
    logic          r_drain_timeout;
    logic          w_exc_req;
    logic          w_cnt_load;
    logic [CW-1:0] w_cnt_val;
    logic          w_cnt_dec;
    logic          w_cnt_zero;
    logic          w_timeout_hit;

    // Gated by rst so stall_all reads 0 while reset is held.
    assign w_exc_req = !rst && (except_typeM != EXCEPT_TYPE_NONE);

    exc_cycle_counter #(
        .WIDTH(CW)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_cnt_load),
        .i_load_val(w_cnt_val),
        .i_dec     (w_cnt_dec),
        .o_zero    (w_cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EXC_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Exception capture and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_type_q        <= '0;
            r_pc_q          <= '0;
            r_drain_timeout <= 1'b0;
        end else begin
            if ((r_state == EXC_ST_IDLE) && w_exc_req) begin
                r_type_q <= except_typeM;
                r_pc_q   <= newPcM;
            end
            if (w_timeout_hit) begin
                r_drain_timeout <= 1'b1;
            end
        end
    end

    // Next state and counter control.
    always_comb begin
        w_next        = r_state;
        w_cnt_load    = 1'b0;
        w_cnt_val     = DRAIN_LOAD;
        w_cnt_dec     = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            EXC_ST_IDLE: begin
                if (w_exc_req) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = DRAIN_LOAD;
                    w_next     = dbus_busy ? EXC_ST_DRAIN : EXC_ST_FLUSH;
                end
            end
            EXC_ST_DRAIN: begin
                if (!dbus_busy) begin
                    w_next = EXC_ST_FLUSH;
                end else if (w_cnt_zero) begin
                    w_timeout_hit = 1'b1;
                    w_next        = EXC_ST_FLUSH;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            EXC_ST_FLUSH: begin
                w_cnt_load = 1'b1;
                w_cnt_val  = REFILL_LOAD;
                w_next     = EXC_ST_REFILL;
            end
            EXC_ST_REFILL: begin
                if (!ibus_busy && w_cnt_zero) begin
                    w_next = EXC_ST_IDLE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            default: w_next = EXC_ST_IDLE;
        endcase
    end

    // Per-state outputs.
    always_comb begin
        stall_all         = 1'b0;
        flushF            = 1'b0;
        flushD            = 1'b0;
        flushE            = 1'b0;
        flushM            = 1'b0;
        flushW            = 1'b0;
        pc_redirect_valid = 1'b0;
        cp0_commit        = 1'b0;
        eret_commit       = 1'b0;
        busy              = 1'b0;
        case (r_state)
            EXC_ST_IDLE: begin
                stall_all = w_exc_req;
            end
            EXC_ST_DRAIN: begin
                stall_all = 1'b1;
                busy      = 1'b1;
            end
            EXC_ST_FLUSH: begin
                stall_all         = 1'b1;
                busy              = 1'b1;
                flushF            = 1'b1;
                flushD            = 1'b1;
                flushE            = 1'b1;
                flushM            = 1'b1;
                flushW            = 1'b1;
                pc_redirect_valid = 1'b1;
                cp0_commit        = (r_type_q != EXCEPT_TYPE_ERET);
                eret_commit       = (r_type_q == EXCEPT_TYPE_ERET);
            end
            EXC_ST_REFILL: begin
                stall_all = 1'b1;
                busy      = 1'b1;
                flushF    = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_redirect   = r_pc_q;
    assign exc_code      = r_type_q[4:0];
    assign drain_timeout = r_drain_timeout;

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Bench for exc_flush_ctrl: inputs for the whole run are generated up front
// (directed scenarios followed by random traffic), and a schedule-level model
// derives the expected output of every cycle from those inputs.
module tb_exc_flush_ctrl;

    localparam int unsigned DT     = 16;
    localparam int unsigned RM     = 2;
    localparam int unsigned NC     = 500;
    localparam int unsigned MARGIN = 64;
    localparam int unsigned LEN    = NC + MARGIN;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] except_typeM;
    logic [31:0] newPcM;
    logic        dbus_busy;
    logic        ibus_busy;
    logic        stall_all;
    logic        flushF, flushD, flushE, flushM, flushW;
    logic        pc_redirect_valid;
    logic [31:0] pc_redirect;
    logic        cp0_commit;
    logic        eret_commit;
    logic [4:0]  exc_code;
    logic        drain_timeout;
    logic        busy;

    always #5 clk = ~clk;

    exc_flush_ctrl #(
        .DRAIN_TIMEOUT(DT),
        .REFILL_MIN   (RM)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .except_typeM     (except_typeM),
        .newPcM           (newPcM),
        .dbus_busy        (dbus_busy),
        .ibus_busy        (ibus_busy),
        .stall_all        (stall_all),
        .flushF           (flushF),
        .flushD           (flushD),
        .flushE           (flushE),
        .flushM           (flushM),
        .flushW           (flushW),
        .pc_redirect_valid(pc_redirect_valid),
        .pc_redirect      (pc_redirect),
        .cp0_commit       (cp0_commit),
        .eret_commit      (eret_commit),
        .exc_code         (exc_code),
        .drain_timeout    (drain_timeout),
        .busy             (busy)
    );

    typedef struct packed {
        logic        stall;
        logic        busy;
        logic        fF;
        logic        fDEMW;
        logic        prv;
        logic        cp0;
        logic        eret;
        logic        dto;
        logic [31:0] pc;
        logic [4:0]  code;
    } exp_t;

    logic [31:0] exc_a [LEN];
    logic [31:0] npc_a [LEN];
    logic        db_a  [LEN];
    logic        ib_a  [LEN];
    exp_t        exp_a [LEN];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_stall"}, -1, {31'd0, stall_all}, 32'd0);
        chk({tag, "_busy"},  -1, {31'd0, busy}, 32'd0);
        chk({tag, "_flush"}, -1, {27'd0, flushF, flushD, flushE, flushM, flushW}, 32'd0);
        chk({tag, "_strb"},  -1, {29'd0, pc_redirect_valid, cp0_commit, eret_commit}, 32'd0);
        chk({tag, "_pc"},    -1, pc_redirect, 32'd0);
        chk({tag, "_code"},  -1, {27'd0, exc_code}, 32'd0);
        chk({tag, "_dto"},   -1, {31'd0, drain_timeout}, 32'd0);
    endtask

    task automatic set_exc(input int p, input logic [31:0] t, input logic [31:0] pc);
        exc_a[p] = t;
        npc_a[p] = pc;
    endtask

    initial begin
        int c, n, f, l, len;
        bit timed;
        logic [31:0] codes [6];
        codes = '{32'h01, 32'h04, 32'h05, 32'h08, 32'h0C, 32'h0E};

        for (int i = 0; i < int'(LEN); i++) begin
            exc_a[i] = '0;
            npc_a[i] = '0;
            db_a[i]  = 1'b0;
            ib_a[i]  = 1'b0;
            exp_a[i] = '0;
        end

        // Directed scenarios.
        set_exc(3, 32'h08, 32'hBFC0_0380);                         // syscall, no drain
        set_exc(10, 32'h04, 32'hBFC0_0380);                        // AdEL, 5 busy cycles
        for (int i = 10; i < 15; i++) db_a[i] = 1'b1;
        set_exc(30, 32'h05, 32'h8000_0180);                        // busy falls as counter hits 0
        for (int i = 30; i < 46; i++) db_a[i] = 1'b1;
        set_exc(60, 32'h0D, 32'h8000_0180);                        // stuck bus, forced flush
        for (int i = 60; i < 91; i++) db_a[i] = 1'b1;
        set_exc(100, 32'h0E, 32'h8000_1234);                       // ERET, ibus busy 4 cycles
        for (int i = 102; i < 106; i++) ib_a[i] = 1'b1;
        set_exc(120, 32'h0C, 32'h8000_0180);                       // overflow
        for (int i = 122; i < 125; i++) set_exc(i, 32'h01, 32'h8000_0200); // interrupt during refill

        // Random traffic.
        for (int i = 140; i < int'(NC); i++) begin
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 6) == 0) exc_a[i] = $urandom | 32'h1;
                else                           exc_a[i] = codes[$urandom_range(0, 5)];
                npc_a[i] = $urandom;
            end
            ib_a[i] = ($urandom_range(0, 2) == 0);
        end
        c = 140;
        while (c < int'(NC)) begin
            c += $urandom_range(1, 4);
            len = $urandom_range(1, 20);
            for (int k = 0; k < len && c < int'(NC); k++) begin
                db_a[c] = 1'b1;
                c++;
            end
        end

        // Reference schedule: each accepted exception occupies [n .. l].
        c = 0;
        while (c < int'(NC)) begin
            if (exc_a[c] != 0) begin
                n = c;
                timed = 1'b0;
                if (!db_a[n]) begin
                    f = n + 1;
                end else begin
                    f = n + DT + 1;
                    timed = 1'b1;
                    for (int k = 1; k <= int'(DT); k++) begin
                        if (!db_a[n + k]) begin
                            f = n + k + 1;
                            timed = 1'b0;
                            break;
                        end
                    end
                end
                l = f + RM;
                while (ib_a[l]) l++;
                for (int i = n; i <= l; i++) exp_a[i].stall = 1'b1;
                for (int i = n + 1; i <= l; i++) exp_a[i].busy = 1'b1;
                for (int i = f; i <= l; i++) exp_a[i].fF = 1'b1;
                exp_a[f].fDEMW = 1'b1;
                exp_a[f].prv   = 1'b1;
                exp_a[f].cp0   = (exc_a[n] != 32'h0E);
                exp_a[f].eret  = (exc_a[n] == 32'h0E);
                for (int i = n + 1; i < int'(LEN); i++) begin
                    exp_a[i].pc   = npc_a[n];
                    exp_a[i].code = exc_a[n][4:0];
                end
                if (timed) for (int i = f; i < int'(LEN); i++) exp_a[i].dto = 1'b1;
                c = l + 1;
            end else begin
                c++;
            end
        end

        // Reset state, with an exception pending on the input.
        rst          = 1'b1;
        except_typeM = 32'h08;
        newPcM       = 32'h1234_5678;
        dbus_busy    = 1'b1;
        ibus_busy    = 1'b1;
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Playback with per-cycle comparison against the schedule.
        for (int i = 0; i < int'(LEN); i++) begin
            except_typeM = exc_a[i];
            newPcM       = npc_a[i];
            dbus_busy    = db_a[i];
            ibus_busy    = ib_a[i];
            @(negedge clk);
            chk("stall_all", i, {31'd0, stall_all}, {31'd0, exp_a[i].stall});
            chk("busy",      i, {31'd0, busy}, {31'd0, exp_a[i].busy});
            chk("flushF",    i, {31'd0, flushF}, {31'd0, exp_a[i].fF});
            chk("flushDEMW", i, {28'd0, flushD, flushE, flushM, flushW}, {28'd0, {4{exp_a[i].fDEMW}}});
            chk("pc_valid",  i, {31'd0, pc_redirect_valid}, {31'd0, exp_a[i].prv});
            chk("cp0_commit",i, {31'd0, cp0_commit}, {31'd0, exp_a[i].cp0});
            chk("eret_commit",i,{31'd0, eret_commit}, {31'd0, exp_a[i].eret});
            chk("pc_redirect",i, pc_redirect, exp_a[i].pc);
            chk("exc_code",  i, {27'd0, exc_code}, {27'd0, exp_a[i].code});
            chk("drain_to",  i, {31'd0, drain_timeout}, {31'd0, exp_a[i].dto});
            @(posedge clk);
            #1;
        end

        // Reset pulsed mid-DRAIN.
        except_typeM = 32'h04;
        newPcM       = 32'hDEAD_BEEF;
        dbus_busy    = 1'b1;
        ibus_busy    = 1'b0;
        @(negedge clk);
        chk("rd_accept_stall", -1, {31'd0, stall_all}, 32'd1);
        @(posedge clk);
        #1;
        except_typeM = 32'h0;
        @(negedge clk);
        chk("rd_drain_busy",  -1, {31'd0, busy}, 32'd1);
        chk("rd_drain_stall", -1, {31'd0, stall_all}, 32'd1);
        except_typeM = 32'h04;
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_in_drain");
        @(posedge clk);
        #1;
        rst          = 1'b0;
        except_typeM = 32'h0;
        dbus_busy    = 1'b0;
        @(negedge clk);
        chk("after_rst_busy", -1, {31'd0, busy}, 32'd0);
        chk("after_rst_dto",  -1, {31'd0, drain_timeout}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
